// File: rtl/wb_arbiter_if.sv
// ============================================================================
//  Module      : wb_arbiter_if
//  Description : Bus bundle between the writeback sources, the writeback
//                arbiter and the register file write port.
//                Optional macro WB_PENDING_EN adds the MUL/DIV issue
//                scoreboard signals.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface wb_arbiter_if #(
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
);
    logic          PIPE_WE;
    logic [4:0]    PIPE_ADDR;
    logic [31:0]   PIPE_DATA;
    logic          MD_VALID;
    logic          MD_READY;
    logic [4:0]    MD_ADDR;
    logic [31:0]   MD_DATA;
    logic          WB_WRITE_EN;
    logic [4:0]    WB_ADDRESS;
    logic [31:0]   WB_DATA;
    logic [CW-1:0] FIFO_COUNT;
`ifdef WB_PENDING_EN
    logic          MD_ISSUE;
    logic [4:0]    MD_ISSUE_ADDR;
    logic [31:0]   PENDING;
`endif

    // Arbiter side
    modport slave (
        input  PIPE_WE, PIPE_ADDR, PIPE_DATA,
        input  MD_VALID, MD_ADDR, MD_DATA,
        output MD_READY,
        output WB_WRITE_EN, WB_ADDRESS, WB_DATA, FIFO_COUNT
`ifdef WB_PENDING_EN
        ,
        input  MD_ISSUE, MD_ISSUE_ADDR,
        output PENDING
`endif
    );

    // Source / register file side
    modport master (
        output PIPE_WE, PIPE_ADDR, PIPE_DATA,
        output MD_VALID, MD_ADDR, MD_DATA,
        input  MD_READY,
        input  WB_WRITE_EN, WB_ADDRESS, WB_DATA, FIFO_COUNT
`ifdef WB_PENDING_EN
        ,
        output MD_ISSUE, MD_ISSUE_ADDR,
        input  PENDING
`endif
    );
endinterface

`default_nettype wire

// File: rtl/wb_arbiter.sv
// ============================================================================
//  Module      : wb_arbiter
//  Description : Register file write-port arbiter. Pipeline writes win; MUL/DIV
//                results queue in a small FIFO and drain into idle slots.
//                Optional macro WB_PENDING_EN adds a pending-register scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_arbiter #(
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  wire logic    CLK,
    input  wire logic    RESET,
    wb_arbiter_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);

    logic [4:0]    fifo_addr_q  [DEPTH];
    logic [4:0]    fifo_addr_d  [DEPTH];
    logic [31:0]   fifo_data_q  [DEPTH];
    logic [31:0]   fifo_data_d  [DEPTH];
    logic          fifo_valid_q [DEPTH];
    logic          fifo_valid_d [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          wb_we_q, wb_we_d;
    logic [4:0]    wb_addr_q, wb_addr_d;
    logic [31:0]   wb_data_q, wb_data_d;

    logic pipe_live;
    logic md_ready;
    logic push;
    logic pop;
    logic head_valid;

    assign pipe_live  = bus.PIPE_WE && (bus.PIPE_ADDR != 5'd0);
    assign md_ready   = !RESET && (count_q < CW'(DEPTH));
    assign push       = bus.MD_VALID && md_ready && (bus.MD_ADDR != 5'd0);
    assign pop        = !pipe_live && (count_q != '0);
    assign head_valid = fifo_valid_q[rd_ptr_q];

    always_comb begin
        fifo_addr_d  = fifo_addr_q;
        fifo_data_d  = fifo_data_q;
        fifo_valid_d = fifo_valid_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        count_d      = count_q + CW'(push) - CW'(pop);
        wb_we_d      = 1'b0;
        wb_addr_d    = wb_addr_q;
        wb_data_d    = wb_data_q;

        // A pipeline write supersedes any older queued result for the same register
        if (pipe_live) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (fifo_addr_q[i] == bus.PIPE_ADDR) begin
                    fifo_valid_d[i] = 1'b0;
                end
            end
        end

        if (pop) begin
            fifo_valid_d[rd_ptr_q] = 1'b0;
            rd_ptr_d               = rd_ptr_q + PW'(1);
        end

        if (push) begin
            fifo_addr_d[wr_ptr_q]  = bus.MD_ADDR;
            fifo_data_d[wr_ptr_q]  = bus.MD_DATA;
            fifo_valid_d[wr_ptr_q] = !(pipe_live && (bus.MD_ADDR == bus.PIPE_ADDR));
            wr_ptr_d               = wr_ptr_q + PW'(1);
        end

        if (pipe_live) begin
            wb_we_d   = 1'b1;
            wb_addr_d = bus.PIPE_ADDR;
            wb_data_d = bus.PIPE_DATA;
        end else if (pop && head_valid) begin
            wb_we_d   = 1'b1;
            wb_addr_d = fifo_addr_q[rd_ptr_q];
            wb_data_d = fifo_data_q[rd_ptr_q];
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_addr_q[i]  <= 5'd0;
                fifo_data_q[i]  <= 32'd0;
                fifo_valid_q[i] <= 1'b0;
            end
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            wb_we_q   <= 1'b0;
            wb_addr_q <= 5'd0;
            wb_data_q <= 32'd0;
        end else begin
            fifo_addr_q  <= fifo_addr_d;
            fifo_data_q  <= fifo_data_d;
            fifo_valid_q <= fifo_valid_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            wb_we_q      <= wb_we_d;
            wb_addr_q    <= wb_addr_d;
            wb_data_q    <= wb_data_d;
        end
    end

    assign bus.MD_READY    = md_ready;
    assign bus.WB_WRITE_EN = wb_we_q;
    assign bus.WB_ADDRESS  = wb_addr_q;
    assign bus.WB_DATA     = wb_data_q;
    assign bus.FIFO_COUNT  = count_q;

`ifdef WB_PENDING_EN
    logic [31:0] pending_q, pending_d;
    logic        squash_hit;

    always_comb begin
        squash_hit = push && (bus.MD_ADDR == bus.PIPE_ADDR);
        for (int i = 0; i < DEPTH; i++) begin
            if (fifo_valid_q[i] && (fifo_addr_q[i] == bus.PIPE_ADDR)) begin
                squash_hit = 1'b1;
            end
        end

        pending_d = pending_q;
        if (pop && head_valid) begin
            pending_d[fifo_addr_q[rd_ptr_q]] = 1'b0;
        end
        if (pipe_live && squash_hit) begin
            pending_d[bus.PIPE_ADDR] = 1'b0;
        end
        // Set is applied last so a same-cycle reissue keeps the bit
        if (bus.MD_ISSUE && (bus.MD_ISSUE_ADDR != 5'd0)) begin
            pending_d[bus.MD_ISSUE_ADDR] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            pending_q <= 32'd0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign bus.PENDING = pending_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_wb_arbiter.sv
// ============================================================================
//  Module      : tb_wb_arbiter
//  Description : Directed vector bench for wb_arbiter (DEPTH=2); the pending
//                scoreboard sequence runs when WB_PENDING_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_arbiter;
    localparam int DEPTH = 2;
    localparam int CW    = $clog2(DEPTH + 1);

    logic clk;
    logic rst;

    wb_arbiter_if #(.DEPTH(DEPTH), .CW(CW)) bus ();

    wb_arbiter #(.DEPTH(DEPTH), .CW(CW)) dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        pwe;
        logic [4:0]  pa;
        logic [31:0] pd;
        logic        mv;
        logic [4:0]  ma;
        logic [31:0] md;
        logic        ewe;
        logic [4:0]  ea;
        logic [31:0] ed;
        int          ec;
        logic        er;
    } vec_t;

    vec_t vecs[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic pwe, input logic [4:0] pa, input logic [31:0] pd,
                         input logic mv, input logic [4:0] ma, input logic [31:0] md);
        bus.PIPE_WE   = pwe;
        bus.PIPE_ADDR = pa;
        bus.PIPE_DATA = pd;
        bus.MD_VALID  = mv;
        bus.MD_ADDR   = ma;
        bus.MD_DATA   = md;
    endtask

    initial begin
        // pwe pa pd | mv ma md | exp we addr data count ready (after edge)
        vecs.push_back('{0, 0, 0,      0, 0, 0,             0, 0, 0,             0, 1}); // idle
        vecs.push_back('{0, 0, 0,      1, 5, 32'hDEADBEEF,  0, 0, 0,             1, 1}); // MD push
        vecs.push_back('{0, 0, 0,      0, 0, 0,             1, 5, 32'hDEADBEEF,  0, 1}); // drain
        vecs.push_back('{0, 0, 0,      0, 0, 0,             0, 5, 32'hDEADBEEF,  0, 1}); // hold
        vecs.push_back('{1, 1, 32'h101, 1, 7, 32'h700,      1, 1, 32'h101,       1, 1}); // starve
        vecs.push_back('{1, 2, 32'h102, 1, 8, 32'h800,      1, 2, 32'h102,       2, 0}); // full
        vecs.push_back('{1, 3, 32'h103, 1, 9, 32'h900,      1, 3, 32'h103,       2, 0}); // rejected
        vecs.push_back('{1, 4, 32'h104, 1, 9, 32'h900,      1, 4, 32'h104,       2, 0});
        vecs.push_back('{0, 0, 0,      1, 9, 32'h900,       1, 7, 32'h700,       1, 1}); // pop 7
        vecs.push_back('{0, 0, 0,      1, 9, 32'h900,       1, 8, 32'h800,       1, 1}); // push 9, pop 8
        vecs.push_back('{0, 0, 0,      0, 0, 0,             1, 9, 32'h900,       0, 1}); // pop 9
        vecs.push_back('{0, 0, 0,      1, 6, 32'h11,        0, 9, 32'h900,       1, 1}); // queue r6
        vecs.push_back('{1, 6, 32'h22, 0, 0, 0,             1, 6, 32'h22,        1, 1}); // squash
        vecs.push_back('{0, 0, 0,      0, 0, 0,             0, 6, 32'h22,        0, 1}); // dead pop
        vecs.push_back('{1, 6, 32'h33, 1, 6, 32'h44,        1, 6, 32'h33,        1, 1}); // same-cycle squash
        vecs.push_back('{0, 0, 0,      0, 0, 0,             0, 6, 32'h33,        0, 1});
        vecs.push_back('{0, 0, 0,      1, 3, 32'h333,       0, 6, 32'h33,        1, 1}); // queue r3
        vecs.push_back('{1, 0, 32'hBAD, 1, 0, 32'h55,       1, 3, 32'h333,       0, 1}); // x0 both sides
        vecs.push_back('{0, 0, 0,      1, 0, 32'h66,        0, 3, 32'h333,       0, 1}); // x0 MD only

        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
`ifdef WB_PENDING_EN
        bus.MD_ISSUE      = 1'b0;
        bus.MD_ISSUE_ADDR = 5'd0;
`endif
        #12;
        chk("rst_we",    {31'd0, bus.WB_WRITE_EN}, 32'd0);
        chk("rst_addr",  {27'd0, bus.WB_ADDRESS},  32'd0);
        chk("rst_data",  bus.WB_DATA,              32'd0);
        chk("rst_count", 32'(bus.FIFO_COUNT),      32'd0);
        chk("rst_ready", {31'd0, bus.MD_READY},    32'd0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i].pwe, vecs[i].pa, vecs[i].pd, vecs[i].mv, vecs[i].ma, vecs[i].md);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_we", i),    {31'd0, bus.WB_WRITE_EN}, {31'd0, vecs[i].ewe});
            chk($sformatf("v%0d_addr", i),  {27'd0, bus.WB_ADDRESS},  {27'd0, vecs[i].ea});
            chk($sformatf("v%0d_data", i),  bus.WB_DATA,              vecs[i].ed);
            chk($sformatf("v%0d_count", i), 32'(bus.FIFO_COUNT),      32'(vecs[i].ec));
            chk($sformatf("v%0d_ready", i), {31'd0, bus.MD_READY},    {31'd0, vecs[i].er});
        end

        // Mid-operation reset with one entry queued and a write in flight
        drive(1, 12, 32'hC0C0, 1, 13, 32'hD0D0);
        @(posedge clk);
        #1;
        chk("pre_rst_we",    {31'd0, bus.WB_WRITE_EN}, 32'd1);
        chk("pre_rst_count", 32'(bus.FIFO_COUNT),      32'd1);
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_we",    {31'd0, bus.WB_WRITE_EN}, 32'd0);
        chk("mid_rst_count", 32'(bus.FIFO_COUNT),      32'd0);
        chk("mid_rst_ready", {31'd0, bus.MD_READY},    32'd0);
        chk("mid_rst_addr",  {27'd0, bus.WB_ADDRESS},  32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_ready", {31'd0, bus.MD_READY},    32'd1);
        chk("post_rst_we",    {31'd0, bus.WB_WRITE_EN}, 32'd0);
        chk("post_rst_count", 32'(bus.FIFO_COUNT),      32'd0);

`ifdef WB_PENDING_EN
        bus.MD_ISSUE = 1'b1; bus.MD_ISSUE_ADDR = 5'd10;
        @(posedge clk); #1;
        chk("pend_set", {31'd0, bus.PENDING[10]}, 32'd1);
        bus.MD_ISSUE = 1'b0;
        drive(0, 0, 0, 1, 10, 32'hA0);
        @(posedge clk); #1;
        chk("pend_queued", {31'd0, bus.PENDING[10]}, 32'd1);
        drive(0, 0, 0, 0, 0, 0);
        bus.MD_ISSUE = 1'b1;
        @(posedge clk); #1;
        chk("pend_reissue_we", {31'd0, bus.WB_WRITE_EN}, 32'd1);
        chk("pend_reissue",    {31'd0, bus.PENDING[10]}, 32'd1);
        bus.MD_ISSUE = 1'b0;
        drive(0, 0, 0, 1, 10, 32'hA1);
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        chk("pend_clear", {31'd0, bus.PENDING[10]}, 32'd0);
        chk("pend_bit0",  {31'd0, bus.PENDING[0]},  32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/wb_arbiter.md
# wb_arbiter

Writeback arbiter between the pipeline's writeback stage, the multi-cycle MUL/DIV unit and the single write port of the 32x32 register file. Pipeline results always win the port. MUL/DIV results are held in a small FIFO and drained into idle write slots. Its registered outputs drive the register file's write-data, write-address and write-enable inputs directly.

## Interface
- DEPTH, 2, MUL/DIV result FIFO entries; power of two, ≥2
- CW, $clog2(DEPTH+1), width of FIFO_COUNT
- CLK  in  1  clock; all state updates on posedge
- RESET  in  1  asynchronous, active-high reset
- PIPE_WE  in  1  pipeline writeback request this cycle (cannot stall)
- PIPE_ADDR  in  5  pipeline destination register
- PIPE_DATA  in  32  pipeline result
- MD_VALID  in  1  MUL/DIV result valid
- MD_READY  out  1  FIFO can accept; transfer when MD_VALID && MD_READY
- MD_ADDR  in  5  MUL/DIV destination register
- MD_DATA  in  32  MUL/DIV result
- WB_WRITE_EN  out  1  register file write enable
- WB_ADDRESS  out  5  register file write address
- WB_DATA  out  32  register file write data
- FIFO_COUNT  out  CW  occupied FIFO entries, including squashed entries

## Operation
- Single clock CLK. RESET is asynchronous and active-high. All flops clear immediately on RESET assertion.
- Pipeline request is live when PIPE_WE=1 and PIPE_ADDR≠0. PIPE_WE with address 0 is dropped and treated as an idle slot.
- Per-cycle selection, in priority order:
  - Live pipeline request → registered onto WB_*.
  - Otherwise, if FIFO is non-empty, pop the head entry. If the head is valid, register it onto WB_*. If it is squashed, pop it with WB_WRITE_EN=0.
  - Otherwise WB_WRITE_EN=0.
- MD_READY = !RESET && (FIFO_COUNT < DEPTH). It never depends on MD_VALID.
- Accepted MUL/DIV results with MD_ADDR=0 are consumed and not enqueued.
- WAW squash: a live pipeline request clears the valid bit of every FIFO entry with a matching address. This includes an entry being pushed in the same cycle.
- Push and pop in the same cycle leave the count unchanged. When the FIFO is full, push is impossible because MD_READY=0.
- FIFO pointers wrap modulo DEPTH.
- WB_DATA and WB_ADDRESS hold their last values when WB_WRITE_EN=0.

## Timing
- Reset values: WB_WRITE_EN=0, WB_ADDRESS=0, WB_DATA=0, FIFO_COUNT=0, all FIFO valid bits 0, PENDING=0.
- MD_READY is 0 while RESET is high and 1 from the first cycle after RESET deasserts.
- Latency is one cycle from selection to WB_*. The register file writes on the following edge.
- Minimum MUL/DIV latency is 2 cycles: push at edge N, pop at edge N+1, WB_* valid after edge N+1. This holds only if no pipeline request is live at N+1.
- A continuous pipeline write stream starves the FIFO indefinitely. MD_READY falls once DEPTH entries are held.
- RESET asserted mid-operation discards all FIFO contents and any in-flight WB_* write.

## Configuration
- WB_PENDING_EN defined adds three ports:
  - MD_ISSUE (in, 1)
  - MD_ISSUE_ADDR (in, 5)
  - PENDING (out, 32): scoreboard of registers awaiting a MUL/DIV result
- PENDING behaviour:
  - Bit set on the edge where MD_ISSUE=1 and MD_ISSUE_ADDR≠0.
  - Bit cleared when a valid MUL/DIV entry for that register is registered onto WB_*, or when the entry is squashed.
  - Set and clear of the same bit in one cycle: set wins.
  - Bit 0 is always 0.
- WB_PENDING_EN undefined: these ports and the scoreboard logic are absent. Everything else is identical.

## Test plan
- Reset: assert RESET mid-cycle with FIFO_COUNT=1 → WB_WRITE_EN=0, FIFO_COUNT=0 and MD_READY=0 immediately; MD_READY=1 one cycle after release.
- Idle MUL/DIV path: MD_VALID with MD_ADDR=5, MD_DATA=0xDEADBEEF, pipeline idle → after two edges WB_WRITE_EN=1, WB_ADDRESS=5, WB_DATA=0xDEADBEEF.
- Starvation and backpressure: PIPE_WE=1 to registers 1..4, three MD results to registers 7, 8, 9 (DEPTH=2):
  - MD_READY=0 after two accepts.
  - Once the pipeline idles, registers 7 and 8 are written in order, then register 9 follows.
- WAW squash: FIFO holds register 6=0x11; pipeline writes register 6=0x22 → WB writes 0x22; the FIFO entry pops with WB_WRITE_EN=0; register 6 is never written with 0x11.
- x0 handling: PIPE_WE=1 with PIPE_ADDR=0 while FIFO holds register 3 → register 3 is written that cycle; an MD result with MD_ADDR=0 is accepted and FIFO_COUNT is unchanged.
- WB_PENDING_EN build: MD_ISSUE to register 10 → PENDING[10]=1; the result is written → PENDING[10]=0; a fresh issue to register 10 in the clear cycle → PENDING[10] stays 1.
